// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming 2-D convolution engine.
//   state_e : top-level controller states
//   cnt_w   : counter width able to hold values 0..n-1
//   out_n   : number of window positions along one axis
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int out_n(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// K*K multiply stage followed by a registered summing stage.
// Both stages share one enable so a downstream stall freezes the whole pipe.
//   clk, rst_n    : clock, async active-low reset
//   en_i          : pipeline advance
//   valid_i       : a_i/b_i carry a real window this cycle
//   a_i, b_i      : window samples and weights, row-major
//   prod_valid_o  : product stage holds a real window
//   valid_o       : sum_o holds a result
//   sum_o         : window sum; forced to 0 whenever no result is held
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int N  = 9,
  parameter int DW = 16,
  parameter int OW = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [N-1:0][DW-1:0]   a_i,
  input  logic [N-1:0][DW-1:0]   b_i,
  output logic                   prod_valid_o,
  output logic                   valid_o,
  output logic [OW-1:0]          sum_o
);

  localparam int PW = 2 * DW;

  logic [N-1:0][PW-1:0] prod_q;
  logic                 prod_valid_q;
  logic                 valid_q;
  logic [OW-1:0]        sum_q;
  logic [OW-1:0]        sum_d;

  // OW carries clog2(N) headroom bits, so the sum can never wrap.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + OW'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      sum_q        <= '0;
    end else if (en_i) begin
      prod_valid_q <= valid_i;
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= PW'(a_i[i]) * PW'(b_i[i]);
      end
      valid_q <= prod_valid_q;
      sum_q   <= prod_valid_q ? sum_d : '0;
    end
  end

  assign prod_valid_o = prod_valid_q;
  assign valid_o      = valid_q;
  assign sum_o        = sum_q;

endmodule

// File: rtl/conv2d_stream_param.sv
// Serial-input 2-D convolution engine. One IMG_W x IMG_W frame and one
// K x K kernel are loaded one sample per cycle, then every valid window
// (stepped by STRIDE) is streamed out, one result per accepted cycle.
//   clk, rst_n    : clock, async active-low reset
//   in_valid      : IFM sample valid (raster order)
//   weight_valid  : weight sample valid (row-major, first K*K load cycles)
//   in_ifm        : IFM sample
//   in_weight     : weight sample
//   in_ready      : engine accepts samples (IDLE/LOAD)
//   out_ready     : downstream takes out_ofm this cycle
//   out_valid     : out_ofm valid
//   out_ofm       : convolution result
//   err           : one-cycle pulse when a load is cut short
//
// state | meaning
// IDLE  | waiting for the first sample of a frame
// LOAD  | capturing samples/weights at the load counter
// CALC  | issuing one window per pipeline advance
// DRAIN | all windows issued, waiting for the last result to leave
module conv2d_stream_param
  import conv_pkg::*;
#(
  parameter  int IMG_W  = 7,
  parameter  int K      = 3,
  parameter  int DW     = 16,
  parameter  int STRIDE = 1,
  localparam int OW     = 2 * DW + $clog2(K * K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          weight_valid,
  input  logic [DW-1:0] in_ifm,
  input  logic [DW-1:0] in_weight,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_ofm,
  output logic          err
);

  localparam int NPIX  = IMG_W * IMG_W;
  localparam int KK    = K * K;
  localparam int AW    = cnt_w(NPIX);
  localparam int WCW   = cnt_w(KK + 1);
  localparam int RW    = cnt_w(IMG_W);
  localparam int OUT_N = out_n(IMG_W, K, STRIDE);
  // Origin of the last window on either axis.
  localparam logic [RW-1:0] LAST = RW'((OUT_N - 1) * STRIDE);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  err_q;
  logic [AW-1:0]         lcnt_q;
  logic [WCW-1:0]        wcnt_q;
  logic [RW-1:0]         row_q;
  logic [RW-1:0]         col_q;
  logic [DW-1:0]         ifm_q [NPIX];
  logic [KK-1:0][DW-1:0] w_q;
  logic [KK-1:0][DW-1:0] win_q;
  logic [KK-1:0][DW-1:0] win_d;
  logic                  win_valid_q;

  logic                  pipe_en;
  logic                  mac_prod_valid;
  logic                  mac_valid;
  logic [OW-1:0]         mac_sum;

  // A held result blocks every stage, including window issue.
  assign pipe_en = !mac_valid || out_ready;

  // Gather the window at the current origin from the frame buffer.
  always_comb begin
    logic [AW-1:0] addr;
    addr  = '0;
    win_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        addr             = AW'((int'(row_q) + r) * IMG_W + int'(col_q) + c);
        win_d[r * K + c] = ifm_q[addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      lcnt_q      <= '0;
      wcnt_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      w_q         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < NPIX; i++) begin
        ifm_q[i] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            ifm_q[0] <= in_ifm;
            if (weight_valid) begin
              w_q[0] <= in_weight;
              wcnt_q <= WCW'(1);
            end else begin
              wcnt_q <= '0;
            end
            lcnt_q  <= AW'(1);
            state_q <= LOAD;
          end
        end

        LOAD: begin
          if (in_valid) begin
            ifm_q[lcnt_q] <= in_ifm;
            if (weight_valid && (wcnt_q < WCW'(KK))) begin
              w_q[wcnt_q] <= in_weight;
              wcnt_q      <= wcnt_q + WCW'(1);
            end
            if (lcnt_q == AW'(NPIX - 1)) begin
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              row_q      <= '0;
              col_q      <= '0;
            end else begin
              lcnt_q <= lcnt_q + AW'(1);
            end
          end else begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end

        CALC: begin
          if (pipe_en) begin
            win_q       <= win_d;
            win_valid_q <= 1'b1;
            if (col_q == LAST) begin
              col_q <= '0;
              if (row_q == LAST) begin
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + RW'(STRIDE);
              end
            end else begin
              col_q <= col_q + RW'(STRIDE);
            end
          end
        end

        DRAIN: begin
          if (pipe_en) begin
            win_valid_q <= 1'b0;
            // Only the result now being accepted is left in flight.
            if (mac_valid && !mac_prod_valid && !win_valid_q) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  conv_mac_tree #(
    .N  (KK),
    .DW (DW),
    .OW (OW)
  ) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (pipe_en),
    .valid_i      (win_valid_q),
    .a_i          (win_q),
    .b_i          (w_q),
    .prod_valid_o (mac_prod_valid),
    .valid_o      (mac_valid),
    .sum_o        (mac_sum)
  );

  assign in_ready  = in_ready_q;
  assign err       = err_q;
  assign out_valid = mac_valid;
  assign out_ofm   = mac_sum;

endmodule

// File: tb/tb_conv2d_stream_param.sv
module tb_conv2d_stream_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, weight_valid;
  logic [15:0] in_ifm, in_weight;
  logic        out_ready, out_ready2;
  logic        in_ready1, out_valid1, err1;
  logic [35:0] out_ofm1;
  logic        in_ready2, out_valid2, err2;
  logic [35:0] out_ofm2;

  int checks = 0;
  int errors = 0;

  logic [35:0] q1[$];
  logic [35:0] q2[$];
  logic [35:0] exp_t2[$];
  logic [35:0] exp_s2[$];
  logic [35:0] exp_n[$];
  logic [35:0] exp_n9[$];

  always #5 clk = ~clk;

  conv2d_stream_param #(.IMG_W(7), .K(3), .DW(16), .STRIDE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .in_ifm       (in_ifm),
    .in_weight    (in_weight),
    .in_ready     (in_ready1),
    .out_ready    (out_ready),
    .out_valid    (out_valid1),
    .out_ofm      (out_ofm1),
    .err          (err1)
  );

  conv2d_stream_param #(.IMG_W(7), .K(3), .DW(16), .STRIDE(2)) dut_s2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .in_ifm       (in_ifm),
    .in_weight    (in_weight),
    .in_ready     (in_ready2),
    .out_ready    (out_ready2),
    .out_valid    (out_valid2),
    .out_ofm      (out_ofm2),
    .err          (err2)
  );

  // Inputs change at posedge+1, so at negedge a valid/ready pair is the
  // handshake that the following posedge completes.
  always @(negedge clk) begin
    if (out_valid1 && out_ready)  q1.push_back(out_ofm1);
    if (out_valid2 && out_ready2) q2.push_back(out_ofm2);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ifm_val(input int mode, input int i);
    case (mode)
      1:       return 16'd1;
      2:       return 16'(i);
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] w_val(input int mode, input int i);
    case (mode)
      1:       return 16'd1;
      2:       return (i == 4) ? 16'd1 : 16'd0;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Called at posedge+1 with both engines idle; returns at T+1 where T is
  // the edge that captured the last sample.
  task automatic send_frame(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid     = 1'b1;
      in_ifm       = ifm_val(mode, i);
      weight_valid = (i < 9);
      in_weight    = w_val(mode, i);
      @(posedge clk); #1;
    end
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    in_ifm       = '0;
    in_weight    = '0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (in_ready1 && !out_valid1 && in_ready2 && !out_valid2) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_idle_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic check_q(input string tag, input logic [35:0] q[$], input logic [35:0] e[$]);
    int n;
    chk({tag, "_count"}, 64'(q.size()), 64'(e.size()));
    n = (q.size() < e.size()) ? q.size() : e.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_out%0d", tag, i), 64'(q[i]), 64'(e[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t2 = '{36'd8,  36'd9,  36'd10, 36'd11, 36'd12,
               36'd15, 36'd16, 36'd17, 36'd18, 36'd19,
               36'd22, 36'd23, 36'd24, 36'd25, 36'd26,
               36'd29, 36'd30, 36'd31, 36'd32, 36'd33,
               36'd36, 36'd37, 36'd38, 36'd39, 36'd40};
    exp_s2 = '{36'd8, 36'd10, 36'd12, 36'd22, 36'd24, 36'd26, 36'd36, 36'd38, 36'd40};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    in_ifm       = '0;
    in_weight    = '0;
    out_ready    = 1'b1;
    out_ready2   = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_out_ofm",   64'(out_ofm1),   64'd0);
    chk("rst_err",       64'(err1),       64'd0);
    chk("rst_in_ready",  64'(in_ready1),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_in_ready_low", 64'(in_ready1), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 64'(in_ready1), 64'd1);

    // Test 1: all ones -> 25 x 9, first result 3 edges after last sample
    q1.delete(); q2.delete();
    send_frame(1, 49);
    chk("t1_lat0", 64'(out_valid1), 64'd0);
    chk("t1_in_ready_calc", 64'(in_ready1), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat1", 64'(out_valid1), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat2", 64'(out_valid1), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat3", 64'(out_valid1), 64'd1);
    chk("t1_first_ofm", 64'(out_ofm1), 64'd9);
    wait_idle("t1");
    exp_n.delete(); exp_n9.delete();
    for (int i = 0; i < 25; i++) exp_n.push_back(36'd9);
    for (int i = 0; i < 9; i++)  exp_n9.push_back(36'd9);
    check_q("t1", q1, exp_n);
    check_q("t1_s2", q2, exp_n9);
    chk("t1_ofm_cleared", 64'(out_ofm1), 64'd0);

    // Test 2 and stride-2 (test 5): ramp IFM, centre-tap kernel
    q1.delete(); q2.delete();
    send_frame(2, 49);
    wait_idle("t2");
    check_q("t2", q1, exp_t2);
    check_q("t5_s2", q2, exp_s2);

    // Test 3: full-scale operands
    q1.delete(); q2.delete();
    send_frame(3, 49);
    wait_idle("t3");
    exp_n.delete(); exp_n9.delete();
    for (int i = 0; i < 25; i++) exp_n.push_back(36'h8FFEE0009);
    for (int i = 0; i < 9; i++)  exp_n9.push_back(36'h8FFEE0009);
    check_q("t3", q1, exp_n);
    check_q("t3_s2", q2, exp_n9);

    // Test 4: stall while the third result (10) is presented
    q1.delete(); q2.delete();
    send_frame(2, 49);
    for (int c = 0; c < 30; c++) begin
      if (q1.size() >= 2) break;
      @(posedge clk); #1;
    end
    chk("t4_two_taken", 64'(q1.size()), 64'd2);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("t4_stall%0d_valid", s), 64'(out_valid1), 64'd1);
      chk($sformatf("t4_stall%0d_ofm", s),   64'(out_ofm1),   64'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("t4");
    check_q("t4", q1, exp_t2);

    // Test 6a: load cut short after 20 samples
    q1.delete(); q2.delete();
    send_frame(1, 20);
    chk("t6_err_before", 64'(err1), 64'd0);
    @(posedge clk); #1;
    chk("t6_err_pulse", 64'(err1), 64'd1);
    chk("t6_in_ready_idle", 64'(in_ready1), 64'd1);
    @(posedge clk); #1;
    chk("t6_err_one_cycle", 64'(err1), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_output", 64'(q1.size()), 64'd0);
    chk("t6_no_output_s2", 64'(q2.size()), 64'd0);
    send_frame(2, 49);
    wait_idle("t6_after_abort");
    check_q("t6_after_abort", q1, exp_t2);

    // Test 6b: reset mid-CALC
    q1.delete(); q2.delete();
    send_frame(1, 49);
    repeat (6) @(posedge clk);
    #1;
    chk("t6r_streaming", 64'(out_valid1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6r_out_valid", 64'(out_valid1), 64'd0);
    chk("t6r_out_ofm",   64'(out_ofm1),   64'd0);
    chk("t6r_in_ready",  64'(in_ready1),  64'd0);
    chk("t6r_err",       64'(err1),       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6r_in_ready_back", 64'(in_ready1), 64'd1);
    q1.delete(); q2.delete();
    send_frame(2, 49);
    wait_idle("t6r_after_reset");
    check_q("t6r_after_reset", q1, exp_t2);
    check_q("t6r_after_reset_s2", q2, exp_s2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
